// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the EX-stage HI/LO unit: ALU op encodings, divider
// state encoding (also used by the hazard unit) and the HI/LO write payload.
package hilo_muldiv_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DIV_CNT_W = 5;

  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, with
// abort support so a flushed divide returns straight to idle.
module hilo_muldiv_div_core
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              idle_c,
  output logic              busy_c,
  output logic              done_c,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0]    rem_q, quo_q, dsr_q;
  logic [DATA_W:0]      rem_sh, diff;
  logic                 fits, last;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign rem_sh = {rem_q, quo_q[DATA_W-1]};
  assign fits   = rem_sh >= {1'b0, dsr_q};
  assign diff   = rem_sh - {1'b0, dsr_q};
  assign last   = cnt_q == DIV_CNT_W'(DIV_STEPS - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
          end
        end
        DIV_RUN: begin
          cnt_q <= cnt_q + DIV_CNT_W'(1);
          quo_q <= {quo_q[DATA_W-2:0], fits};
          rem_q <= fits ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    idle_c  = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        idle_c = 1'b1;
        if (start) state_d = DIV_RUN;
      end
      DIV_RUN: begin
        busy_c = 1'b1;
        if (abort)     state_d = DIV_IDLE;
        else if (last) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        done_c  = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// EX-stage HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO and a stalling
// iterative DIV/DIVU built on the unsigned divider core plus sign fix-up.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        alucontrol,
  input  logic              start,
  input  logic              annul,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_done
);

  logic              idle_c, busy_c, done_c;
  logic              issue_c, is_div, is_sdiv, div_issue;
  logic [DATA_W-1:0] a_mag, b_mag, quo, rem;
  logic              q_neg_q, r_neg_q;
  logic [63:0]       prod_s, prod_u;
  hilo_t             wr_d;
  logic              wr_en;

  // Only an idle unit accepts an instruction; held divide ops are ignored.
  assign issue_c   = start & ~annul & idle_c;
  assign is_sdiv   = alucontrol == EXE_DIV_OP;
  assign is_div    = is_sdiv | (alucontrol == EXE_DIVU_OP);
  assign div_issue = issue_c & is_div;

  assign stall    = div_issue | (busy_c & ~annul);
  assign div_done = done_c & ~annul;

  assign a_mag = (is_sdiv && src_a[DATA_W-1]) ? -src_a : src_a;
  assign b_mag = (is_sdiv && src_b[DATA_W-1]) ? -src_b : src_b;

  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  hilo_muldiv_div_core #(.DIV_STEPS(DIV_STEPS)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (div_issue),
    .abort    (annul),
    .dividend (a_mag),
    .divisor  (b_mag),
    .idle_c   (idle_c),
    .busy_c   (busy_c),
    .done_c   (done_c),
    .quotient (quo),
    .remainder(rem)
  );

  // Sign fix-up flags captured with the operands at divide issue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (div_issue) begin
      q_neg_q <= is_sdiv & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
      r_neg_q <= is_sdiv & src_a[DATA_W-1];
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_d.hi = hi;
    wr_d.lo = lo;
    if (div_done) begin
      wr_en   = 1'b1;
      wr_d.hi = r_neg_q ? -rem : rem;
      wr_d.lo = q_neg_q ? -quo : quo;
    end else if (issue_c) begin
      case (alucontrol)
        EXE_MULT_OP:  begin wr_en = 1'b1; wr_d = prod_s; end
        EXE_MULTU_OP: begin wr_en = 1'b1; wr_d = prod_u; end
        EXE_MTHI_OP:  begin wr_en = 1'b1; wr_d.hi = src_a; end
        EXE_MTLO_OP:  begin wr_en = 1'b1; wr_d.lo = src_a; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (wr_en) begin
      hi <= wr_d.hi;
      lo <= wr_d.lo;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: table of ops with expected HI/LO and
// stall length, plus hand-written annul and mid-divide reset sequences.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  alucontrol;
  logic        start, annul;
  logic [31:0] src_a, src_b;
  logic        stall;
  logic [31:0] hi, lo;
  logic        div_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t  vecs[15];
  hilo_t exp_q[$];

  hilo_muldiv #(.DIV_STEPS(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .alucontrol(alucontrol),
    .start     (start),
    .annul     (annul),
    .src_a     (src_a),
    .src_b     (src_b),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo),
    .div_done  (div_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op at the current negedge, follow the stall, then compare HI/LO.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int ec,
                        input string tag);
    int    cyc;
    hilo_t e;
    alucontrol = op;
    src_a      = a;
    src_b      = b;
    start      = 1'b1;
    annul      = 1'b0;
    exp_q.push_back('{hi: eh, lo: el});
    #1;
    cyc = 0;
    while (stall && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check({tag, " stall_cycles"}, 64'(cyc), 64'(ec));
    check({tag, " div_done_pulse"}, 64'(div_done), (ec != 0) ? 64'd1 : 64'd0);
    @(negedge clk);
    start      = 1'b0;
    alucontrol = 8'h00;
    #1;
    e = exp_q.pop_front();
    check({tag, " hi"}, 64'(hi), 64'(e.hi));
    check({tag, " lo"}, 64'(lo), 64'(e.lo));
  endtask

  initial begin
    vecs[0]  = '{EXE_MULT_OP,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 0};
    vecs[1]  = '{EXE_MULTU_OP, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 0};
    vecs[2]  = '{EXE_DIV_OP,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{EXE_DIVU_OP,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[4]  = '{EXE_DIVU_OP,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 33};
    vecs[5]  = '{EXE_DIV_OP,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[6]  = '{EXE_MTHI_OP,  32'h0000000A, 32'd0,        32'h0000000A, 32'h80000000, 0};
    vecs[7]  = '{EXE_MTLO_OP,  32'h0000000B, 32'd0,        32'h0000000A, 32'h0000000B, 0};
    vecs[8]  = '{EXE_DIV_OP,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[9]  = '{EXE_MULT_OP,  32'd7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 0};
    vecs[10] = '{EXE_DIV_OP,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'h00000001, 33};
    vecs[11] = '{8'h20,        32'h12345678, 32'h9,        32'hFFFFFFF8, 32'h00000001, 0};
    vecs[12] = '{EXE_DIVU_OP,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 33};
    vecs[13] = '{EXE_MTHI_OP,  32'h0000000A, 32'd0,        32'h0000000A, 32'h19999999, 0};
    vecs[14] = '{EXE_MTLO_OP,  32'h0000000B, 32'd0,        32'h0000000A, 32'h0000000B, 0};

    resetn = 1'b0;
    start = 1'b0;
    annul = 1'b0;
    alucontrol = 8'h00;
    src_a = '0;
    src_b = '0;
    @(negedge clk);
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    check("reset div_done", 64'(div_done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].cyc,
             $sformatf("vec%0d", i));

    // Annul a signed divide in RUN cycle 10; HI/LO must keep 0xA/0xB.
    @(negedge clk);
    alucontrol = EXE_DIV_OP;
    src_a = 32'hFFFFFFF9;
    src_b = 32'd2;
    start = 1'b1;
    for (int k = 0; k < 11; k++) @(negedge clk);
    #1;
    check("annul pre stall", 64'(stall), 64'd1);
    annul = 1'b1;
    #1;
    check("annul stall drop", 64'(stall), 64'd0);
    check("annul div_done", 64'(div_done), 64'd0);
    @(negedge clk);
    annul = 1'b0;
    #1;
    check("annul hi kept", 64'(hi), 64'hA);
    check("annul lo kept", 64'(lo), 64'hB);
    run_op(EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 33, "after_annul");

    // Annulled MTHI must not write.
    alucontrol = EXE_MTHI_OP;
    src_a = 32'h55;
    start = 1'b1;
    annul = 1'b1;
    #1;
    check("mthi annul stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    #1;
    check("mthi annul hi", 64'(hi), 64'd2);

    // Reset in the middle of a divide.
    @(negedge clk);
    alucontrol = EXE_DIV_OP;
    src_a = 32'd1000;
    src_b = 32'd3;
    start = 1'b1;
    for (int k = 0; k < 6; k++) @(negedge clk);
    start = 1'b0;
    resetn = 1'b0;
    #1;
    check("midreset stall", 64'(stall), 64'd0);
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    check("midreset div_done", 64'(div_done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op(EXE_MULTU_OP, 32'd3, 32'd4, 32'd0, 32'd12, 0, "post_reset");
    run_op(EXE_DIV_OP, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 33, "post_reset_div");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
